// File: rtl/sound_pkg.sv
// Shared types and default widths for the sound-effect path: scheduler, ROM loader, tone generator.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package sound_pkg;

    localparam int DEF_NREQ    = 4;
    localparam int DEF_PSIZE   = 24;
    localparam int DEF_DSIZE   = 8;
    localparam int DEF_AW      = 6;
    localparam int DEF_SEG_LEN = 16;

    // Sequencer states; anything other than IDLE counts as busy.
    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        LOAD,
        PLAY
    } snd_state_t;

    // One sound ROM word. A dur of zero marks the end of a segment.
    typedef struct packed {
        logic [DEF_PSIZE-1:0] period;
        logic [DEF_DSIZE-1:0] dur;
    } sound_entry_t;

endpackage

// File: rtl/sound_sched_prio_enc.sv
// Highest-index priority encoder: idx is the top set bit of req, vld when any bit is set.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its input.
module prio_enc #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         vld
);

    // Scan upward so the last hit, the highest index, wins.
    always_comb begin
        idx = '0;
        vld = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                idx = W'(i);
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sound_sched.sv
// Arbitrates one-shot sound requests and steps through the winner's ROM segment, driving tone_per.
// Latency: req at edge N -> ROM fetch after N+1 -> tone_per valid after N+3.
// Backpressure: none; requests latch into pending, equal or higher priority preempts during PLAY.
module sound_sched
    import sound_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int PSIZE   = DEF_PSIZE,
    parameter int DSIZE   = DEF_DSIZE,
    parameter int AW      = DEF_AW,
    parameter int SEG_LEN = DEF_SEG_LEN,
    localparam int IDW    = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tick,
    input  logic [NREQ-1:0]        req,
    output logic [AW-1:0]          rom_addr,
    output logic                   rom_en,
    input  logic [PSIZE+DSIZE-1:0] rom_data,
    output logic [PSIZE-1:0]       tone_per,
    output logic                   busy,
    output logic [IDW-1:0]         active_id,
    output logic                   seq_done
);

    localparam int OW = $clog2(SEG_LEN);
    localparam int CW = DSIZE + 4;

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [OW-1:0] OFF_ONE  = OW'(1);
    localparam logic [OW-1:0] OFF_LAST = OW'(SEG_LEN - 1);

    snd_state_t      state;
    logic [NREQ-1:0] pending;
    logic [OW-1:0]   offset;
    logic [CW-1:0]   dur_cnt;
    logic [CW-1:0]   dur_lim;

    logic [IDW-1:0]  winner;
    logic            win_vld;
    logic [NREQ-1:0] win_mask;
    logic            launch;
    logic [PSIZE-1:0] ent_period;
    logic [DSIZE-1:0] ent_dur;

    // Segments are power-of-two aligned, so the address is a plain concatenation.
    function automatic logic [AW-1:0] seg_addr(input logic [IDW-1:0] id, input logic [OW-1:0] off);
        return AW'({id, off});
    endfunction

    prio_enc #(
        .N (NREQ),
        .W (IDW)
    ) u_prio_enc (
        .req (pending),
        .idx (winner),
        .vld (win_vld)
    );

    assign ent_period = rom_data[PSIZE+DSIZE-1:DSIZE];
    assign ent_dur    = rom_data[DSIZE-1:0];
    assign win_mask   = NREQ'(1) << winner;
    assign busy       = (state != IDLE);

    // Start a segment from IDLE, or preempt mid-note when the winner is not lower priority.
    always_comb begin
        launch = 1'b0;
        if (win_vld) begin
            if (state == IDLE) begin
                launch = 1'b1;
            end else if (state == PLAY && winner >= active_id) begin
                launch = 1'b1;
            end
        end
    end

    // Sequencer: pending capture, segment launch, per-note fetch/load/play and termination.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pending   <= '0;
            offset    <= '0;
            tone_per  <= '0;
            active_id <= '0;
            seq_done  <= 1'b0;
            rom_en    <= 1'b0;
            rom_addr  <= '0;
            dur_cnt   <= '0;
            dur_lim   <= '0;
        end else begin
            rom_en   <= 1'b0;
            seq_done <= 1'b0;
            // A same-cycle request from the launched requester is absorbed.
            pending  <= launch ? ((pending | req) & ~win_mask) : (pending | req);

            if (launch) begin
                // tone_per is left alone so a preempted note keeps sounding until the new LOAD.
                active_id <= winner;
                offset    <= '0;
                rom_en    <= 1'b1;
                rom_addr  <= seg_addr(winner, '0);
                state     <= FETCH;
            end else begin
                case (state)
                    IDLE: begin
                    end
                    FETCH: begin
                        state <= LOAD;
                    end
                    LOAD: begin
                        if (ent_dur == '0) begin
                            tone_per <= '0;
                            seq_done <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            // A zero period with nonzero dur is a timed rest.
                            tone_per <= ent_period;
                            dur_lim  <= {ent_dur, 4'b0000};
                            dur_cnt  <= '0;
                            state    <= PLAY;
                        end
                    end
                    PLAY: begin
                        if (tick) begin
                            if (dur_cnt == dur_lim - CNT_ONE) begin
                                if (offset == OFF_LAST) begin
                                    // Last slot of the segment ends it without a further fetch.
                                    tone_per <= '0;
                                    seq_done <= 1'b1;
                                    state    <= IDLE;
                                end else begin
                                    offset   <= offset + OFF_ONE;
                                    rom_en   <= 1'b1;
                                    rom_addr <= seg_addr(active_id, offset + OFF_ONE);
                                    state    <= FETCH;
                                end
                            end else begin
                                dur_cnt <= dur_cnt + CNT_ONE;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/sound_sched.md
Name: sound_sched

Overview:
- Arbitrates one-shot sound-effect requests (paddle hit, wall bounce, score, game over) and sequences multi-note effects from a synchronous sound ROM.
- Each effect is a segment of ROM entries {period, duration}.
- Drives the period input of the square-wave tone generator.
- Sits between the SPI data decoder (which provides request pulses) and the tone generator.

Parameters:
NREQ, 4, number of requesters; index NREQ-1 has highest priority
PSIZE, 24, tone period width in clk cycles
DSIZE, 8, duration field width
AW, 6, ROM address width
SEG_LEN, 16, entries per effect segment; base address of requester i = i*SEG_LEN

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
tick  input  1  single-cycle duration tick enable, 1.6 kHz
req  input  NREQ  per-requester request, sampled every clk
rom_addr  output  AW  sound ROM read address
rom_en  output  1  ROM read enable
rom_data  input  PSIZE+DSIZE  {period, dur}, valid 1 clk after rom_en
tone_per  output  PSIZE  period to tone generator; 0 = silence
busy  output  1  high in any state other than IDLE
active_id  output  $clog2(NREQ)  requester currently sequenced
seq_done  output  1  one-clk pulse when a segment ends normally

Behaviour:
- Reset values: state=IDLE, pending=0, offset=0, tone_per=0, busy=0, active_id=0, seq_done=0, rom_en=0, rom_addr=0, dur_cnt=0. Reset mid-sequence aborts immediately and silences the output.
- pending[i] is set on any clk where req[i]=1. A level held high re-arms pending every cycle.
- Selection: winner = highest set index of pending.
- Launch: pending[winner] clears; a req[winner] in the same cycle is absorbed (clear wins). offset<=0, active_id<=winner, next state FETCH.
- IDLE: if pending!=0, launch.
- FETCH (1 clk): rom_en=1, rom_addr=active_id*SEG_LEN+offset → LOAD.
- LOAD (1 clk): latch rom_data.
  - If dur==0 (terminator): tone_per<=0, seq_done<=1 for 1 clk, → IDLE.
  - Otherwise: tone_per<=period, dur_lim<={dur,4'b0}, dur_cnt<=0, → PLAY.
  - period==0 with dur!=0 is a timed rest.
- PLAY:
  - Each tick: dur_cnt++.
  - When tick and dur_cnt==dur_lim-1 (note lasted dur*16 ticks): offset++, → FETCH.
  - If offset was SEG_LEN-1, treat as terminator instead: tone_per<=0, seq_done pulse, → IDLE.
- Preemption: checked only in PLAY.
  - If pending!=0 and winner>=active_id, launch immediately, even mid-note.
  - winner==active_id restarts the effect from offset 0.
  - tone_per keeps its old value until the new LOAD. No seq_done pulse on preemption.
- Lower-priority pending requests wait and play after the current segment ends.
- Ticks arriving in FETCH/LOAD are dropped (at most 2 clk out of ~31k per tick, so not audible).
- tone_per is held through FETCH/LOAD between notes, so there is no glitch.
- Latency: req high at edge N → pending at N → FETCH after N+1 → LOAD after N+2 → tone_per valid after edge N+3.
- Widths: dur_cnt and dur_lim are DSIZE+4 bits. dur=255 gives 4080 ticks; no overflow. rom_addr = {active_id, offset[log2 SEG_LEN-1:0]}; SEG_LEN must be a power of two and NREQ*SEG_LEN<=2**AW.

Decomposition:
- Package sound_pkg: state enum (IDLE, FETCH, LOAD, PLAY), PSIZE/DSIZE/AW defaults, and a sound_entry_t struct {period, dur}. The ROM loader and tone generator share these.
- One sub-module, prio_enc: a parameterised highest-index priority encoder with valid output.
- The ROM itself stays outside this block.

Test Plan:
- ROM[0]={1000,2}, ROM[1]={0,0}; 1-clk pulse on req[0] → tone_per=1000 three edges later; busy=1; after exactly 32 ticks, terminator fetch; seq_done pulse; tone_per=0; busy=0.
- req[0] and req[2] in the same cycle → active_id=2, rom_addr=32 first. After segment 2 ends, segment 0 plays (rom_addr=0) with no intervening req.
- Segment 1 playing (offset 1, mid-note); pulse req[3] → rom_addr=48 within 2 clk, no seq_done for segment 1. pulse req[0] instead → ignored until segment 1 finishes.
- req[1] re-pulsed while segment 1 plays offset 3 → restart at rom_addr=16; tone_per stays at old value until LOAD.
- Segment with 16 nonzero entries, dur=1 each → after 16×16 ticks, seq_done fires with no fetch of rom_addr=SEG_LEN.
- reset asserted asynchronously during PLAY with pending=4'b0101 → all outputs 0 immediately; after release, no playback occurs without a new req.
